// File: rtl/async_valid_handshake_ctrl_pkg.sv
// Shared definitions for the async valid handshake sequencer.
//   STATE_W : width of the encoded sequencer state
//   state_t : sequencer states, values fixed for debug visibility on io_state
package async_valid_handshake_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_ANNOUNCE = 3'd1,
    ST_ACTIVE   = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_QUIESCE  = 3'd4,
    ST_HOLDOFF  = 3'd5,
    ST_ERROR    = 3'd6
  } state_t;

endpackage

// File: rtl/async_valid_handshake_ctrl_sat_counter.sv
// Up/down saturating counter with synchronous clear.
//   clk   : clock
//   rst   : synchronous active-high reset
//   clr   : synchronous clear (same effect as reset)
//   inc   : count up by one (dropped when count == MAX)
//   dec   : count down by one (ignored when count == 0)
//   count : current value; inc and dec together leave it unchanged
module handshake_sat_counter #(
  parameter int unsigned    W   = 4,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !dec && (count != MAX)) begin
      count <= count + W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/async_valid_handshake_ctrl.sv
// Per-side bring-up/tear-down sequencer for an asynchronous valid crossing.
// Announces local valid to the peer, waits for the synchronized peer valid,
// enables the local queue while both sides are up, drains in-flight traffic
// on tear-down, and holds off long enough for the peer synchronizer to flush
// before a new announce. ANNOUNCE and QUIESCE are guarded by a timeout.
//   clock           : local domain clock
//   reset           : synchronous, active-high reset
//   io_enable_req   : level request to bring the link up
//   io_peer_valid   : peer valid, already synchronized into this domain
//   io_inflight_inc : one transaction enqueued this cycle
//   io_inflight_dec : one transaction completed this cycle
//   io_err_clear    : pulse, leaves ERROR
//   io_local_valid  : local valid toward the peer (ANNOUNCE/ACTIVE/DRAIN)
//   io_link_up      : queue enable, ACTIVE only
//   io_busy         : ANNOUNCE/DRAIN/QUIESCE/HOLDOFF
//   io_timeout      : ERROR
//   io_state        : current encoded state
// The four status outputs are registered decodes of the current state, so
// they follow a state change by one cycle.
module async_valid_handshake_ctrl
  import async_valid_handshake_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_DEPTH     = 3,
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned TIMEOUT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_enable_req,
  input  logic               io_peer_valid,
  input  logic               io_inflight_inc,
  input  logic               io_inflight_dec,
  input  logic               io_err_clear,
  output logic               io_local_valid,
  output logic               io_link_up,
  output logic               io_busy,
  output logic               io_timeout,
  output logic [STATE_W-1:0] io_state
);

  // Sized so SYNC_DEPTH itself is representable, also for SYNC_DEPTH = 0.
  localparam int unsigned HO_W = $clog2(SYNC_DEPTH + 2);

  state_t                state;
  state_t                next_state;
  logic [CNT_W-1:0]      inflight;
  logic [TIMEOUT_W-1:0]  timer;
  logic [HO_W-1:0]       holdoff_cnt;
  logic                  state_change;
  logic                  timer_run;
  logic                  timer_hit;
  logic                  holdoff_done;

  assign state_change = (next_state != state);
  assign timer_run    = (state == ST_ANNOUNCE) || (state == ST_QUIESCE);
  assign timer_hit    = (timer == TIMEOUT_W'(TIMEOUT_CYCLES));
  assign holdoff_done = (holdoff_cnt == HO_W'(SYNC_DEPTH));

  handshake_sat_counter #(
    .W   (CNT_W),
    .MAX ('1)
  ) u_inflight (
    .clk   (clock),
    .rst   (reset),
    .clr   (1'b0),
    .inc   (io_inflight_inc),
    .dec   (io_inflight_dec),
    .count (inflight)
  );

  handshake_sat_counter #(
    .W   (TIMEOUT_W),
    .MAX (TIMEOUT_W'(TIMEOUT_CYCLES))
  ) u_timer (
    .clk   (clock),
    .rst   (reset),
    .clr   (state_change),
    .inc   (timer_run),
    .dec   (1'b0),
    .count (timer)
  );

  // Counts cycles spent in HOLDOFF; zero on the first HOLDOFF cycle so the
  // state is held for SYNC_DEPTH+1 cycles in total.
  always_ff @(posedge clock) begin
    if (reset || state_change) begin
      holdoff_cnt <= '0;
    end else if (state == ST_HOLDOFF) begin
      holdoff_cnt <= holdoff_cnt + HO_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (io_enable_req) next_state = ST_ANNOUNCE;
      end
      ST_ANNOUNCE: begin
        if (io_peer_valid)       next_state = ST_ACTIVE;
        else if (timer_hit)      next_state = ST_ERROR;
        else if (!io_enable_req) next_state = ST_QUIESCE;
      end
      ST_ACTIVE: begin
        if (!io_enable_req || !io_peer_valid) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (inflight == '0) next_state = ST_QUIESCE;
      end
      ST_QUIESCE: begin
        if (!io_peer_valid)  next_state = ST_HOLDOFF;
        else if (timer_hit)  next_state = ST_ERROR;
      end
      ST_HOLDOFF: begin
        if (holdoff_done) next_state = ST_IDLE;
      end
      ST_ERROR: begin
        if (io_err_clear) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      io_local_valid <= 1'b0;
      io_link_up     <= 1'b0;
      io_busy        <= 1'b0;
      io_timeout     <= 1'b0;
    end else begin
      state          <= next_state;
      io_local_valid <= (state == ST_ANNOUNCE) || (state == ST_ACTIVE) ||
                        (state == ST_DRAIN);
      io_link_up     <= (state == ST_ACTIVE);
      io_busy        <= (state == ST_ANNOUNCE) || (state == ST_DRAIN) ||
                        (state == ST_QUIESCE)  || (state == ST_HOLDOFF);
      io_timeout     <= (state == ST_ERROR);
    end
  end

  assign io_state = state;

endmodule

// File: tb/tb_async_valid_handshake_ctrl.sv
// Self-checking bench for async_valid_handshake_ctrl (SYNC_DEPTH=3, CNT_W=4,
// TIMEOUT_CYCLES=20). Each step drives one cycle of inputs together with the
// state expected after the clock edge; expected status outputs are the decode
// of the state expected before that edge.
module tb_async_valid_handshake_ctrl;
  import async_valid_handshake_ctrl_pkg::*;

  localparam int unsigned TO = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic       io_enable_req, io_peer_valid, io_inflight_inc, io_inflight_dec;
  logic       io_err_clear;
  logic       io_local_valid, io_link_up, io_busy, io_timeout;
  logic [2:0] io_state;

  always #5 clock = ~clock;

  async_valid_handshake_ctrl #(
    .SYNC_DEPTH     (3),
    .CNT_W          (4),
    .TIMEOUT_W      (16),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .io_enable_req   (io_enable_req),
    .io_peer_valid   (io_peer_valid),
    .io_inflight_inc (io_inflight_inc),
    .io_inflight_dec (io_inflight_dec),
    .io_err_clear    (io_err_clear),
    .io_local_valid  (io_local_valid),
    .io_link_up      (io_link_up),
    .io_busy         (io_busy),
    .io_timeout      (io_timeout),
    .io_state        (io_state)
  );

  typedef struct {
    logic   en, pv, inc, dec, clr, rst;
    state_t st;
  } vec_t;

  typedef struct {
    state_t st;
    logic   lv, lu, busy, to;
    int     idx;
  } exp_t;

  vec_t   tbl[$];
  exp_t   sb[$];
  state_t prev_exp = ST_IDLE;
  int     n_checks = 0;
  int     n_errors = 0;
  int     step_no  = 0;

  task automatic check(input string name, input int got, input int exp_v);
    n_checks++;
    if (got != exp_v) begin
      n_errors++;
      $display("FAIL %s step=%0d got=%0d exp=%0d", name, step_no, got, exp_v);
    end
  endtask

  function automatic void add(input logic en, pv, inc, dec, clr, rst,
                              input state_t st);
    vec_t v;
    v.en = en; v.pv = pv; v.inc = inc; v.dec = dec; v.clr = clr; v.rst = rst;
    v.st = st;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic en, pv, inc, dec, clr, rst,
                      input state_t st);
    exp_t e;
    io_enable_req   = en;
    io_peer_valid   = pv;
    io_inflight_inc = inc;
    io_inflight_dec = dec;
    io_err_clear    = clr;
    reset           = rst;
    e.idx  = step_no;
    e.st   = rst ? ST_IDLE : st;
    e.lv   = !rst && (prev_exp inside {ST_ANNOUNCE, ST_ACTIVE, ST_DRAIN});
    e.lu   = !rst && (prev_exp == ST_ACTIVE);
    e.busy = !rst && (prev_exp inside {ST_ANNOUNCE, ST_DRAIN, ST_QUIESCE, ST_HOLDOFF});
    e.to   = !rst && (prev_exp == ST_ERROR);
    sb.push_back(e);
    prev_exp = e.st;
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("state",       int'(io_state),       int'(e.st));
      check("local_valid", int'(io_local_valid), int'(e.lv));
      check("link_up",     int'(io_link_up),     int'(e.lu));
      check("busy",        int'(io_busy),        int'(e.busy));
      check("timeout",     int'(io_timeout),     int'(e.to));
    end
    step_no++;
  endtask

  task automatic idle(input logic en, pv, input state_t st);
    step(en, pv, 1'b0, 1'b0, 1'b0, 1'b0, st);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog step=%0d", step_no);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    io_enable_req = 1'b0; io_peer_valid = 1'b0; io_inflight_inc = 1'b0;
    io_inflight_dec = 1'b0; io_err_clear = 1'b0;
    @(posedge clock);
    #1;

    // Bring-up, drain with traffic, holdoff, abort, peer priority, peer drop.
    add(0,0,0,0,0,1, ST_IDLE);
    add(0,0,0,0,0,0, ST_IDLE);
    add(1,0,0,0,0,0, ST_ANNOUNCE);
    for (int i = 0; i < 3; i++) add(1,0,0,0,0,0, ST_ANNOUNCE);
    add(1,1,0,0,0,0, ST_ACTIVE);
    add(1,1,0,0,0,0, ST_ACTIVE);
    for (int i = 0; i < 3; i++) add(1,1,1,0,0,0, ST_ACTIVE);
    add(0,1,0,0,0,0, ST_DRAIN);
    add(0,1,0,1,0,0, ST_DRAIN);
    add(0,1,0,0,0,0, ST_DRAIN);
    add(0,1,0,1,0,0, ST_DRAIN);
    add(0,1,0,0,0,0, ST_DRAIN);
    add(0,1,0,1,0,0, ST_DRAIN);
    add(0,1,0,0,0,0, ST_QUIESCE);
    add(0,1,0,0,0,0, ST_QUIESCE);
    add(0,0,0,0,0,0, ST_HOLDOFF);
    for (int i = 0; i < 3; i++) add(1,0,0,0,0,0, ST_HOLDOFF);
    add(1,0,0,0,0,0, ST_IDLE);
    add(1,0,0,0,0,0, ST_ANNOUNCE);
    add(0,0,0,0,0,0, ST_QUIESCE);
    add(0,0,0,0,0,0, ST_HOLDOFF);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0,0, ST_HOLDOFF);
    add(0,0,0,0,0,0, ST_IDLE);
    add(1,0,0,0,0,0, ST_ANNOUNCE);
    add(0,1,0,0,0,0, ST_ACTIVE);
    add(1,1,0,0,0,0, ST_ACTIVE);
    add(1,0,0,0,0,0, ST_DRAIN);
    add(1,0,0,0,0,0, ST_QUIESCE);
    add(1,0,0,0,0,0, ST_HOLDOFF);
    for (int i = 0; i < 3; i++) add(1,0,0,0,0,0, ST_HOLDOFF);
    add(1,0,0,0,0,0, ST_IDLE);
    add(1,0,0,0,0,0, ST_ANNOUNCE);
    add(0,0,0,0,0,0, ST_QUIESCE);
    add(0,0,0,0,0,0, ST_HOLDOFF);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0,0, ST_HOLDOFF);
    add(0,0,0,0,0,0, ST_IDLE);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].en, tbl[i].pv, tbl[i].inc, tbl[i].dec, tbl[i].clr,
           tbl[i].rst, tbl[i].st);
    check("inflight_after_drain", int'(dut.inflight), 0);

    // Inflight counter corners, exercised while IDLE.
    step(0,0,1,0,0,0, ST_IDLE);
    step(0,0,1,0,0,0, ST_IDLE);
    check("inflight_two", int'(dut.inflight), 2);
    step(0,0,1,1,0,0, ST_IDLE);
    check("inflight_inc_dec", int'(dut.inflight), 2);
    step(0,0,0,1,0,0, ST_IDLE);
    step(0,0,0,1,0,0, ST_IDLE);
    step(0,0,0,1,0,0, ST_IDLE);
    check("inflight_dec_at_zero", int'(dut.inflight), 0);
    for (int i = 0; i < 16; i++) step(0,0,1,0,0,0, ST_IDLE);
    check("inflight_saturate", int'(dut.inflight), 15);
    step(0,0,1,0,0,0, ST_IDLE);
    check("inflight_inc_at_max", int'(dut.inflight), 15);
    for (int i = 0; i < 10; i++) step(0,0,0,1,0,0, ST_IDLE);
    check("inflight_five", int'(dut.inflight), 5);

    // Reset in the middle of DRAIN with traffic outstanding.
    idle(1,0, ST_ANNOUNCE);
    idle(1,1, ST_ACTIVE);
    idle(0,1, ST_DRAIN);
    idle(0,1, ST_DRAIN);
    step(0,1,0,0,0,1, ST_IDLE);
    check("inflight_after_reset", int'(dut.inflight), 0);

    // ANNOUNCE timeout, ERROR holds until err_clear.
    idle(1,0, ST_ANNOUNCE);
    for (int i = 0; i < TO; i++) idle(1,0, ST_ANNOUNCE);
    idle(1,0, ST_ERROR);
    idle(1,0, ST_ERROR);
    idle(1,1, ST_ERROR);
    step(0,0,0,0,1,0, ST_IDLE);
    idle(0,0, ST_IDLE);

    // Peer valid wins over a timeout in the same cycle; then QUIESCE timeout.
    idle(1,0, ST_ANNOUNCE);
    for (int i = 0; i < TO; i++) idle(1,0, ST_ANNOUNCE);
    idle(1,1, ST_ACTIVE);
    idle(0,1, ST_DRAIN);
    idle(0,1, ST_QUIESCE);
    for (int i = 0; i < TO; i++) idle(0,1, ST_QUIESCE);
    idle(0,1, ST_ERROR);
    step(0,1,0,0,1,0, ST_IDLE);

    // Timeout wins over abort in the same cycle.
    idle(1,0, ST_ANNOUNCE);
    for (int i = 0; i < TO; i++) idle(1,0, ST_ANNOUNCE);
    idle(0,0, ST_ERROR);
    step(0,0,0,0,1,0, ST_IDLE);
    idle(0,0, ST_IDLE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
